// File: rtl/calc_pkg.sv
// Shared key-code constants, entry FSM state encoding and small helpers for
// the calculator keypad entry path.
package calc_pkg;

    localparam logic [3:0] KeyAdd = 4'hA;
    localparam logic [3:0] KeySub = 4'hB;
    localparam logic [3:0] KeyMul = 4'hC;
    localparam logic [3:0] KeyDiv = 4'hD;
    localparam logic [3:0] KeyClr = 4'hE;
    localparam logic [3:0] KeyEq  = 4'hF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StEntry = 2'd1,
        StHold  = 2'd2
    } entry_state_e;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

endpackage

// File: rtl/m_key_debounce.sv
// Scan-sampled key debouncer: emits a single-cycle event with the key code once a
// press is stable for DEB_N scans, then waits for DEB_N released scans before re-arming.
module m_key_debounce #(
    parameter int unsigned DEB_N = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_done,
    input  logic       pushed,
    input  logic [3:0] code,
    output logic       key_ev,
    output logic [3:0] key_code
);

    localparam logic [3:0] DebMax = 4'(DEB_N);

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] last_q, last_d;
    logic       armed_q, armed_d;
    logic [3:0] cnt_inc;

    assign key_code = code;

    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        armed_d = armed_q;
        key_ev  = 1'b0;
        cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        if (scan_done) begin
            if (armed_q) begin
                // cnt_q == 0 means no press is being counted, so any code starts a fresh run
                if (!pushed) begin
                    cnt_d = 4'd0;
                end else if (code == last_q && cnt_q != 4'd0) begin
                    cnt_d = cnt_inc;
                end else begin
                    cnt_d  = 4'd1;
                    last_d = code;
                end
                if (cnt_d == DebMax) begin
                    key_ev  = 1'b1;
                    armed_d = 1'b0;
                    cnt_d   = 4'd0;
                end
            end else begin
                cnt_d = pushed ? 4'd0 : cnt_inc;
                if (cnt_d == DebMax) begin
                    armed_d = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            last_q  <= 4'd0;
            armed_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/m_calc_entry.sv
// Calculator operand entry: debounced keys build a 4-digit BCD entry and
// operator/equals keys hand {operand, op} downstream over a valid/ready token.
module m_calc_entry
    import calc_pkg::*;
#(
    parameter int unsigned DEB_N = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_done,
    input  logic        pushed,
    input  logic [3:0]  code,
    output logic [15:0] disp,
    output logic        tok_valid,
    output logic [15:0] tok_operand,
    output logic [3:0]  tok_op,
    input  logic        tok_ready,
    output logic        key_drop
);

    logic       key_ev;
    logic [3:0] key_code;

    m_key_debounce #(
        .DEB_N(DEB_N)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_done(scan_done),
        .pushed   (pushed),
        .code     (code),
        .key_ev   (key_ev),
        .key_code (key_code)
    );

    entry_state_e state_q, state_d;
    logic [15:0]  disp_q, disp_d;
    logic [2:0]   ndig_q, ndig_d;
    logic [15:0]  operand_q, operand_d;
    logic [3:0]   op_q, op_d;
    logic         drop_q, drop_d;

    always_comb begin
        state_d   = state_q;
        disp_d    = disp_q;
        ndig_d    = ndig_q;
        operand_d = operand_q;
        op_d      = op_q;
        drop_d    = 1'b0;
        unique case (state_q)
            StIdle, StEntry: begin
                if (key_ev) begin
                    if (is_digit(key_code)) begin
                        if (state_q == StIdle) begin
                            disp_d  = {12'h000, key_code};
                            ndig_d  = 3'd1;
                            state_d = StEntry;
                        end else if (ndig_q == 3'd4) begin
                            drop_d = 1'b1;
                        end else begin
                            disp_d = {disp_q[11:0], key_code};
                            ndig_d = ndig_q + 3'd1;
                        end
                    end else if (key_code == KeyClr) begin
                        disp_d  = 16'h0000;
                        ndig_d  = 3'd0;
                        state_d = StIdle;
                    end else begin
                        operand_d = disp_q;
                        op_d      = key_code;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                // The token is frozen here; every key is dropped, even one landing on the transfer cycle
                if (key_ev) begin
                    drop_d = 1'b1;
                end
                if (tok_ready) begin
                    disp_d  = 16'h0000;
                    ndig_d  = 3'd0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            disp_q    <= 16'h0000;
            ndig_q    <= 3'd0;
            operand_q <= 16'h0000;
            op_q      <= 4'h0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            disp_q    <= disp_d;
            ndig_q    <= ndig_d;
            operand_q <= operand_d;
            op_q      <= op_d;
            drop_q    <= drop_d;
        end
    end

    assign disp        = disp_q;
    assign tok_valid   = (state_q == StHold);
    assign tok_operand = operand_q;
    assign tok_op      = op_q;
    assign key_drop    = drop_q;

endmodule

// File: tb/tb_m_calc_entry.sv
// Scoreboard bench for m_calc_entry: directed key sequences queue expected display,
// token and drop observations; a negedge monitor pops and compares them.
module tb_m_calc_entry;

    localparam int ObDisp = 0;
    localparam int ObDrop = 1;
    localparam int ObTok  = 2;

    logic        clk;
    logic        rst_n;
    logic        scan_done;
    logic        pushed;
    logic [3:0]  code;
    logic [15:0] disp;
    logic        tok_valid;
    logic [15:0] tok_operand;
    logic [3:0]  tok_op;
    logic        tok_ready;
    logic        key_drop;

    int checks = 0;
    int fails  = 0;
    logic mon_off = 1'b1;
    logic [15:0] prev_disp = 16'h0000;
    logic        prev_valid = 1'b0;

    int          exp_k[$];
    logic [19:0] exp_v[$];

    m_calc_entry #(
        .DEB_N(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_done  (scan_done),
        .pushed     (pushed),
        .code       (code),
        .disp       (disp),
        .tok_valid  (tok_valid),
        .tok_operand(tok_operand),
        .tok_op     (tok_op),
        .tok_ready  (tok_ready),
        .key_drop   (key_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    task automatic expect_ob(input int k, input logic [19:0] v);
        exp_k.push_back(k);
        exp_v.push_back(v);
    endtask

    task automatic observe(input int k, input logic [19:0] v);
        int          ek;
        logic [19:0] ev;
        if (exp_k.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_obs: got kind %0d value %h, need nothing", k, v);
        end else begin
            ek = exp_k.pop_front();
            ev = exp_v.pop_front();
            check("obs_kind", 20'(k), 20'(ek));
            check("obs_value", v, ev);
        end
    endtask

    // Monitor: each negedge, report token launch, display change and drop pulse in that order
    always @(negedge clk) begin
        if (rst_n && !mon_off) begin
            if (tok_valid && !prev_valid) observe(ObTok, {tok_op, tok_operand});
            if (disp != prev_disp) observe(ObDisp, {4'h0, disp});
            if (key_drop) observe(ObDrop, 20'h0);
        end
        prev_disp  = disp;
        prev_valid = tok_valid;
    end

    task automatic scan(input logic p, input logic [3:0] c);
        @(posedge clk);
        #1 scan_done = 1'b1;
        pushed = p;
        code   = c;
        @(posedge clk);
        #1 scan_done = 1'b0;
        pushed = 1'b0;
    endtask

    task automatic press(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) scan(1'b1, c);
    endtask

    task automatic rel(input int n);
        for (int i = 0; i < n; i++) scan(1'b0, 4'h0);
    endtask

    task automatic key(input logic [3:0] c);
        press(c, 3);
        rel(3);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1 tok_ready = 1'b1;
        @(posedge clk);
        #1 tok_ready = 1'b0;
    endtask

    task automatic async_reset();
        mon_off = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_disp", {4'h0, disp}, 20'h0);
        check("rst_valid", {19'h0, tok_valid}, 20'h0);
        check("rst_operand", {4'h0, tok_operand}, 20'h0);
        check("rst_op", {16'h0, tok_op}, 20'h0);
        check("rst_drop", {19'h0, key_drop}, 20'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_off = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        scan_done = 1'b0;
        pushed    = 1'b0;
        code      = 4'h0;
        tok_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_disp", {4'h0, disp}, 20'h0);
        check("init_valid", {19'h0, tok_valid}, 20'h0);
        check("init_operand", {4'h0, tok_operand}, 20'h0);
        check("init_op", {16'h0, tok_op}, 20'h0);
        check("init_drop", {19'h0, key_drop}, 20'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 mon_off = 1'b0;

        // Single press with exact one-clock latency, then a long hold that must not repeat
        expect_ob(ObDisp, 20'h00005);
        press(4'h5, 2);
        @(posedge clk);
        #1 scan_done = 1'b1;
        pushed = 1'b1;
        code   = 4'h5;
        @(negedge clk);
        check("lat_before", {4'h0, disp}, 20'h00000);
        @(posedge clk);
        #1;
        check("lat_after", {4'h0, disp}, 20'h00005);
        scan_done = 1'b0;
        pushed    = 1'b0;
        press(4'h5, 10);
        rel(3);
        expect_ob(ObDisp, 20'h00000);
        key(4'hE);

        // A code change mid-count restarts the count
        press(4'h1, 2);
        expect_ob(ObDisp, 20'h00002);
        press(4'h2, 3);
        rel(3);
        expect_ob(ObDisp, 20'h00000);
        key(4'hE);

        // Four digits, a dropped fifth, then an add token
        expect_ob(ObDisp, 20'h00001);
        expect_ob(ObDisp, 20'h00012);
        expect_ob(ObDisp, 20'h00123);
        expect_ob(ObDisp, 20'h01234);
        expect_ob(ObDrop, 20'h0);
        expect_ob(ObTok, 20'hA1234);
        key(4'h1);
        key(4'h2);
        key(4'h3);
        key(4'h4);
        key(4'h5);
        key(4'hA);

        // Keys in HOLD are dropped and the token stays put until accepted
        expect_ob(ObDrop, 20'h0);
        expect_ob(ObDrop, 20'h0);
        key(4'h7);
        key(4'hE);
        check("hold_valid", {19'h0, tok_valid}, 20'h1);
        check("hold_token", {tok_op, tok_operand}, 20'hA1234);
        expect_ob(ObDisp, 20'h00000);
        pulse_ready();
        check("xfer_valid", {19'h0, tok_valid}, 20'h0);
        check("xfer_disp", {4'h0, disp}, 20'h0);

        // Key event on the same cycle as the transfer
        expect_ob(ObDisp, 20'h00009);
        expect_ob(ObTok, 20'hF0009);
        key(4'h9);
        key(4'hF);
        press(4'h3, 2);
        expect_ob(ObDisp, 20'h00000);
        expect_ob(ObDrop, 20'h0);
        @(posedge clk);
        #1 scan_done = 1'b1;
        pushed    = 1'b1;
        code      = 4'h3;
        tok_ready = 1'b1;
        @(posedge clk);
        #1 scan_done = 1'b0;
        pushed    = 1'b0;
        tok_ready = 1'b0;
        check("coinc_valid", {19'h0, tok_valid}, 20'h0);
        rel(3);

        // Operator with no digits gives a zero operand
        expect_ob(ObTok, 20'hB0000);
        key(4'hB);
        pulse_ready();
        check("empty_xfer_valid", {19'h0, tok_valid}, 20'h0);

        // Reset in HOLD, then reset mid-debounce; the next press needs three full scans
        expect_ob(ObDisp, 20'h00004);
        expect_ob(ObTok, 20'hC0004);
        key(4'h4);
        key(4'hC);
        async_reset();
        press(4'h6, 2);
        async_reset();
        press(4'h6, 2);
        expect_ob(ObDisp, 20'h00006);
        scan(1'b1, 4'h6);
        rel(3);

        repeat (5) @(posedge clk);
        check("sb_empty", 20'(exp_k.size()), 20'h0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
